// File: rtl/memory_pkg.sv
// memory_pkg: shared types and helpers for sync_ram.
//   state_t   - sequencer state (CLEAR sweeps the array to zero, IDLE serves requests)
//   even_par  - even-parity bit of a word. Used only when MEM_PARITY_EN is defined.
//               Callers zero-extend narrower words to PAR_MAX_W bits.
package memory_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int PAR_MAX_W = 1024;

  function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ram_array.sv
// ram_array: DEPTH x WORD_W storage with one shared address.
//   It has a synchronous write port and a registered read port.
// Ports:
//   clk, rst  clock; asynchronous active-high reset (clears the read register only)
//   we        write enable: word[addr] <= wdata on the rising edge
//   re        read enable: rdata <= word[addr], or 0 when rzero is set
//   rzero     load zero into rdata instead of reading (out-of-range reads)
//   addr      word address; the caller keeps it below DEPTH whenever we or (re & ~rzero) is set
//   wdata     write word
//   rdata     registered read word; holds its value between reads
module ram_array #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic              rzero,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Storage has no reset; the clear sequencer in sync_ram initialises it.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= rzero ? '0 : mem[addr];
  end

endmodule

// File: rtl/sync_ram.sv
// sync_ram: synchronous single-port RAM with a hardware clear sequencer.
//   Reads have one cycle of latency. Out-of-range addresses are detected.
// Optional feature: define MEM_PARITY_EN to store an even-parity bit per word.
//   That option adds the inj_perr input and the perr output.
// Ports:
//   clk, rst   clock; asynchronous active-high reset (restarts the clear)
//   req, we    access request (accepted only while ready) and write select
//   address    word address; address >= DEPTH is flagged via addr_err
//   data_in    write data
//   clear      start zeroing the whole array (honoured in IDLE, beats req)
//   ready      1 in IDLE; busy = 1 while clearing
//   data_out   registered read data; rvalid pulses one cycle after an accepted read
//   addr_err   pulses one cycle after an accepted out-of-range access
//   inj_perr   (MEM_PARITY_EN) invert the stored parity on an accepted write
//   perr       (MEM_PARITY_EN) pulses with rvalid when the word read fails parity
//
// state | meaning
// CLEAR | writes 0 to word[ptr] each edge; leaves after word DEPTH-1 is written
// IDLE  | accepts one read/write per cycle; clear request returns to CLEAR
module sync_ram
  import memory_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clear,
  output logic              ready,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              rvalid,
  output logic              addr_err
`ifdef MEM_PARITY_EN
  ,
  input  logic              inj_perr,
  output logic              perr
`endif
);

`ifdef MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              in_range;
  logic              accept;
  logic              arr_we, arr_re;
  logic [ADDR_W-1:0] arr_addr;
  logic [MEM_W-1:0]  arr_wdata;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rdata;

  // Extra top bit keeps the compare exact when DEPTH == 2**ADDR_W.
  assign in_range = {1'b0, address} < DEPTH_EXT;

`ifdef MEM_PARITY_EN
  assign wr_word = {even_par({{(PAR_MAX_W - DATA_W){1'b0}}, data_in}) ^ inj_perr, data_in};
`else
  assign wr_word = data_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    accept    = 1'b0;
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_addr  = address;
    arr_wdata = wr_word;
    case (state_q)
      CLEAR: begin
        // An all-zero word also carries correct (zero) parity.
        arr_we    = 1'b1;
        arr_addr  = ptr_q;
        arr_wdata = '0;
        if (ptr_q == LAST_ADDR) state_d = IDLE;
        else                    ptr_d   = ptr_q + 1'b1;
      end
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end else if (req) begin
          accept = 1'b1;
          arr_we = we & in_range;
          arr_re = ~we;
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  ram_array #(
    .WORD_W (MEM_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .re    (arr_re),
    .rzero (~in_range),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid   <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rvalid   <= accept & ~we;
      addr_err <= accept & ~in_range;
    end
  end

`ifdef MEM_PARITY_EN
  // Remembers that the pending read hit real storage; a zero-filled out-of-range
  // read must never report a parity error.
  logic chk_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chk_q <= 1'b0;
    else     chk_q <= accept & ~we & in_range;
  end
  assign perr = chk_q & even_par({{(PAR_MAX_W - MEM_W){1'b0}}, rdata});
`endif

  assign data_out = rdata[DATA_W-1:0];
  assign ready    = (state_q == IDLE);
  assign busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_sync_ram.sv
// tb_sync_ram: directed, table-driven bench for sync_ram (DEPTH=128).
// Inputs change on the falling edge; responses are sampled on the next falling edge.
// Define MEM_PARITY_EN to include the parity ports and their checks.
module tb_sync_ram;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 128;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req = 1'b0;
  logic              we = 1'b0;
  logic              clear = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic              ready, busy, rvalid, addr_err;
  logic [DATA_W-1:0] data_out;
`ifdef MEM_PARITY_EN
  logic              inj_perr = 1'b0;
  logic              perr;
`endif

  sync_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .address  (address),
    .data_in  (data_in),
    .clear    (clear),
    .ready    (ready),
    .busy     (busy),
    .data_out (data_out),
    .rvalid   (rvalid),
    .addr_err (addr_err)
`ifdef MEM_PARITY_EN
    ,
    .inj_perr (inj_perr),
    .perr     (perr)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       r;
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    logic       ev;
    logic [7:0] ed;
    logic       ee;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic w, logic [7:0] a, logic [7:0] d,
                              logic ev, logic [7:0] ed, logic ee);
    vec_t v;
    v.r = r; v.w = w; v.a = a; v.d = d; v.ev = ev; v.ed = ed; v.ee = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic access(input logic w, input logic [7:0] a, input logic [7:0] d);
    req = 1'b1; we = w; address = a; data_in = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //              req  we   addr   data   rvalid data_out addr_err
    vecs.push_back(mk(1, 0, 8'h7F, 8'h00, 1, 8'h00, 0));
    vecs.push_back(mk(1, 1, 8'h10, 8'hA5, 0, 8'h00, 0));
    vecs.push_back(mk(1, 0, 8'h10, 8'h00, 1, 8'hA5, 0));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'hA5, 0));
    vecs.push_back(mk(1, 0, 8'h80, 8'h00, 1, 8'h00, 1));
    vecs.push_back(mk(1, 1, 8'h90, 8'h55, 0, 8'h00, 1));
    vecs.push_back(mk(1, 0, 8'h10, 8'h00, 1, 8'hA5, 0));
    vecs.push_back(mk(1, 1, 8'h7F, 8'h77, 0, 8'hA5, 0));
    vecs.push_back(mk(1, 0, 8'h7F, 8'h00, 1, 8'h77, 0));
    vecs.push_back(mk(1, 1, 8'h11, 8'h3C, 0, 8'h77, 0));
    vecs.push_back(mk(1, 0, 8'h11, 8'h00, 1, 8'h3C, 0));
    vecs.push_back(mk(1, 0, 8'h10, 8'h00, 1, 8'hA5, 0));
    vecs.push_back(mk(1, 0, 8'hFF, 8'h00, 1, 8'h00, 1));
    vecs.push_back(mk(1, 0, 8'h00, 8'h00, 1, 8'h00, 0));
    vecs.push_back(mk(0, 1, 8'h20, 8'h99, 0, 8'h00, 0));
    vecs.push_back(mk(1, 0, 8'h20, 8'h00, 1, 8'h00, 0));

    // Reset values
    #1;
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_addr_err", 32'(addr_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_ready", 32'(ready), 32'h0);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    count_busy(n);
    chk("init_clear_edges", 32'(n), 32'(DEPTH));
    chk("init_ready", 32'(ready), 32'h1);
    @(negedge clk);

    // Table-driven single-cycle accesses
    foreach (vecs[i]) begin
      req = vecs[i].r; we = vecs[i].w; address = vecs[i].a; data_in = vecs[i].d;
      @(negedge clk);
      chk($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_data_out", i), 32'(data_out), 32'(vecs[i].ed));
      chk($sformatf("vec%0d_addr_err", i), 32'(addr_err), 32'(vecs[i].ee));
      chk($sformatf("vec%0d_ready", i), 32'(ready), 32'h1);
    end
    req = 1'b0; we = 1'b0;

    // Clear beats a same-cycle request
    for (int i = 0; i < 4; i++) access(1'b1, 8'(i), 8'(8'h11 * (i + 1)));
    access(1'b0, 8'h02, 8'h00);
    chk("pre_clear_read", 32'(data_out), 32'h33);
    req = 1'b1; we = 1'b0; address = 8'h01; clear = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0; clear = 1'b0;
    chk("clear_drop_rvalid", 32'(rvalid), 32'h0);
    chk("clear_drop_data", 32'(data_out), 32'h33);
    chk("clear_busy", 32'(busy), 32'h1);
    chk("clear_ready", 32'(ready), 32'h0);
    count_busy(n);
    chk("clear_edges", 32'(n), 32'(DEPTH));
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      access(1'b0, 8'(i), 8'h00);
      chk($sformatf("post_clear_rvalid%0d", i), 32'(rvalid), 32'h1);
      chk($sformatf("post_clear_data%0d", i), 32'(data_out), 32'h0);
    end

    // Requests ignored while clearing; reset mid-clear restarts the sweep
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    req = 1'b1; we = 1'b0; address = 8'h80;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (k == 10 || k == 40) begin
        chk($sformatf("clearing_rvalid_k%0d", k), 32'(rvalid), 32'h0);
        chk($sformatf("clearing_addr_err_k%0d", k), 32'(addr_err), 32'h0);
      end
    end
    req = 1'b0;
    chk("midclear_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #2;
    chk("midrst_busy", 32'(busy), 32'h1);
    chk("midrst_data_out", 32'(data_out), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    count_busy(n);
    chk("midrst_clear_edges", 32'(n), 32'(DEPTH));
    @(negedge clk);
    access(1'b0, 8'h10, 8'h00);
    chk("after_midrst_rvalid", 32'(rvalid), 32'h1);
    chk("after_midrst_data", 32'(data_out), 32'h0);

`ifdef MEM_PARITY_EN
    inj_perr = 1'b1;
    access(1'b1, 8'h30, 8'h0F);
    inj_perr = 1'b0;
    access(1'b0, 8'h30, 8'h00);
    chk("par_inj_rvalid", 32'(rvalid), 32'h1);
    chk("par_inj_data", 32'(data_out), 32'h0F);
    chk("par_inj_perr", 32'(perr), 32'h1);
    access(1'b1, 8'h31, 8'h0F);
    access(1'b0, 8'h31, 8'h00);
    chk("par_ok_data", 32'(data_out), 32'h0F);
    chk("par_ok_perr", 32'(perr), 32'h0);
    access(1'b0, 8'h80, 8'h00);
    chk("par_oor_err", 32'(addr_err), 32'h1);
    chk("par_oor_perr", 32'(perr), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_ram.md
# sync_ram

Parametrised synchronous single-port RAM, the clocked successor to the combinational scratch memory. It adds configurable width and depth, a one-cycle registered read with a valid strobe, and out-of-range detection. A hardware clear sequencer zeroes every word after reset or on request. It sits between the datapath/controller and local storage, and accepts one request per cycle when ready.

## Interface
Parameters:
- DATA_W, 8, data word width (≥1)
- ADDR_W, 8, address width (≥1)
- DEPTH, 128, number of implemented words; must satisfy 2 ≤ DEPTH ≤ 2**ADDR_W

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  1  access request, sampled when ready=1
- we  input  1  1 = write, 0 = read; qualifies req
- address  input  ADDR_W  word address
- data_in  input  DATA_W  write data
- clear  input  1  request zeroing of the whole array; honoured in IDLE only
- ready  output  1  1 in IDLE (requests accepted)
- busy  output  1  1 while clearing
- data_out  output  DATA_W  registered read data; holds value between reads
- rvalid  output  1  one-cycle pulse: data_out valid for the read accepted on the previous edge
- addr_err  output  1  one-cycle pulse, same timing as rvalid/write completion, for address ≥ DEPTH

## Operation
- FSM states: CLEAR, IDLE. Async reset forces CLEAR, clear pointer = 0.
- CLEAR: each edge writes 0 to word[ptr], ptr++. When the word at ptr = DEPTH-1 is written, go to IDLE. req is ignored; no rvalid and no addr_err are produced.
- IDLE, clear=1: go to CLEAR, ptr=0. clear has priority over a same-cycle req; that req is dropped with no response.
- IDLE, req=1, we=1, address<DEPTH: word[address] ← data_in. data_out is unchanged and rvalid stays 0.
- IDLE, req=1, we=0, address<DEPTH: data_out ← word[address]; rvalid=1 on the next cycle.
- address ≥ DEPTH: a write is discarded. A read returns data_out=0 with rvalid=1. addr_err pulses in both cases.
- Back-to-back accesses are allowed every cycle in IDLE. A read following a write to the same address returns the new data.
- Reset during CLEAR or IDLE restarts the clear from word 0. Memory contents are undefined until the clear completes.

## Timing
- Reset values: data_out=0, rvalid=0, addr_err=0, busy=1, ready=0 (and perr=0 when enabled).
- Clear duration: exactly DEPTH rising edges after rst deasserts, or after the edge that samples clear. busy falls and ready rises after the final clear edge.
- Read latency: 1 cycle, from the accepting edge to data_out/rvalid.
- Write latency: takes effect at the accepting edge.
- ready and busy are decoded from registered state only, with no combinational path from inputs.

## Configuration
- MEM_PARITY_EN defined:
  - each word stores an extra even-parity bit; CLEAR writes parity 0
  - adds input inj_perr (1 bit): when high on an accepted write, the stored parity bit is inverted
  - adds output perr (1 bit): pulses with rvalid when a read word fails its parity check
  - perr is never asserted for out-of-range reads
- MEM_PARITY_EN undefined: no parity storage, no inj_perr or perr ports; the array is DATA_W wide.

## Structure
- Package memory_pkg holds:
  - the state enum (CLEAR, IDLE)
  - the even-parity function, used under MEM_PARITY_EN
- One sub-module, ram_array: storage of DEPTH × (DATA_W[+1]) with one synchronous write port and one registered read port. sync_ram holds the FSM, clear pointer, range check and output strobes.

## Test plan
- Reset, DEPTH=128: busy=1 for exactly 128 edges after rst falls, then ready=1. A read of addr 0x7F returns 0 with rvalid one cycle later.
- Write 0xA5 to 0x10, then read 0x10 on the next cycle → data_out=0xA5, rvalid pulse. A write produces no rvalid.
- Read 0x80 with DEPTH=128 → data_out=0x00, rvalid=1, addr_err=1. A write of 0x55 to 0x90 → addr_err=1 and no array word changes.
- Fill addresses 0..3 with 0x11..0x44, assert clear in the same cycle as a req → req dropped, 128 busy cycles, then reads of 0..3 return 0.
- Assert rst mid-clear at ptr=50 → clear restarts, busy lasts a further 128 edges after release.
- MEM_PARITY_EN: write 0x0F with inj_perr=1, then read → perr=1 with rvalid and data_out=0x0F. Write 0x0F with inj_perr=0, then read → perr=0.
